// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: integrates a tuning word and emits a 10-bit phase for the quadrant-fold stage.
// Optional build macro PHASE_DITHER_EN adds LFSR dither to the phase truncation only.
module dds_phase_accum #(
   parameter int ACC_W = 32,
   parameter int OUT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [ACC_W-1:0] tw_in,
   input  logic             tw_valid,
   output logic             tw_ready,
   input  logic             sync_clr,
   input  logic [OUT_W-1:0] phase_off,
   output logic [OUT_W-1:0] phase_out,
   output logic             phase_valid,
   output logic             wrap
);

   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] tw_act_q, tw_act_d;
   logic [ACC_W-1:0] tw_shd_q, tw_shd_d;
   logic [OUT_W-1:0] phase_q, phase_d;
   logic             wrap_q, wrap_d;
   logic             ready_q, ready_d;
   logic [ACC_W:0]   sum_w;
   logic [ACC_W-1:0] dith_w;
   logic             hs_w;

   function automatic logic [OUT_W-1:0] trunc_phase(input logic [ACC_W-1:0] a,
                                                    input logic [OUT_W-1:0] off);
      return a[ACC_W-1 -: OUT_W] + off;
   endfunction

   assign sum_w = {1'b0, acc_q} + {1'b0, tw_act_q};
   assign hs_w  = tw_valid & ready_q;

`ifdef PHASE_DITHER_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst)
         lfsr_q <= 16'hACE1;
      else if (state_q != IDLE)
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   assign dith_w = ACC_W'(lfsr_q);
`else
   assign dith_w = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         tw_act_q <= '0;
         tw_shd_q <= '0;
         phase_q  <= '0;
         wrap_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         tw_act_q <= tw_act_d;
         tw_shd_q <= tw_shd_d;
         phase_q  <= phase_d;
         wrap_q   <= wrap_d;
         ready_q  <= ready_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      tw_act_d = tw_act_q;
      tw_shd_d = tw_shd_q;
      phase_d  = phase_q;
      wrap_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (hs_w) tw_act_d = tw_in;
            if (en)   state_d  = RUN;
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               if (hs_w) tw_act_d = tw_in;
            end else begin
               acc_d  = sum_w[ACC_W-1:0];
               wrap_d = sum_w[ACC_W];
               if (hs_w) begin
                  tw_shd_d = tw_in;
                  state_d  = PEND;
               end
            end
         end
         PEND: begin
            if (!en) begin
               tw_act_d = tw_shd_q;
               state_d  = IDLE;
            end else if (tw_act_q == '0) begin
               tw_act_d = tw_shd_q;
               state_d  = RUN;
            end else begin
               // The wrap edge itself still uses the old word; the new one starts next cycle.
               acc_d  = sum_w[ACC_W-1:0];
               wrap_d = sum_w[ACC_W];
               if (sum_w[ACC_W]) begin
                  tw_act_d = tw_shd_q;
                  state_d  = RUN;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) phase_d = trunc_phase(acc_d + dith_w, phase_off);

      if (sync_clr) begin
         acc_d   = '0;
         wrap_d  = 1'b0;
         phase_d = phase_off;
         if (state_q == PEND) begin
            tw_act_d = tw_shd_q;
            state_d  = RUN;
         end
      end

      ready_d = (state_d != PEND);
   end

   always_comb begin
      tw_ready    = ready_q;
      phase_valid = (state_q != IDLE);
      phase_out   = phase_q;
      wrap        = wrap_q;
   end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Bench for dds_phase_accum: directed vector table, full-cycle sweep and randomized run against a model.
module tb_dds_phase_accum;

   logic        clk = 1'b0;
   logic        rst, en, tw_valid, sync_clr;
   logic [31:0] tw_in;
   logic [9:0]  phase_off;
   logic        tw_ready, phase_valid, wrap;
   logic [9:0]  phase_out;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dds_phase_accum #(.ACC_W(32), .OUT_W(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .tw_in      (tw_in),
      .tw_valid   (tw_valid),
      .tw_ready   (tw_ready),
      .sync_clr   (sync_clr),
      .phase_off  (phase_off),
      .phase_out  (phase_out),
      .phase_valid(phase_valid),
      .wrap       (wrap)
   );

   typedef struct {
      bit          rst, en, vld, clr;
      logic [31:0] tw;
      logic [9:0]  off;
      logic [9:0]  ph;
      bit          wr, rdy, pv;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit e, input bit v, input bit c, input logic [31:0] tw,
                      input logic [9:0] off, input logic [9:0] ph, input bit wr, input bit rdy,
                      input bit pv);
      vec_t x;
      x.rst = r; x.en = e; x.vld = v; x.clr = c; x.tw = tw; x.off = off;
      x.ph = ph; x.wr = wr; x.rdy = rdy; x.pv = pv;
      tbl.push_back(x);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input bit e, input bit v, input bit c, input logic [31:0] tw,
                        input logic [9:0] off);
      rst = r; en = e; tw_valid = v; sync_clr = c; tw_in = tw; phase_off = off;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: accumulator as a plain 32-bit integer plus run/pending flags.
   bit [31:0] m_acc, m_act, m_shd;
   bit        m_run, m_pend, m_wrap;
   bit [9:0]  m_phase;

   task automatic model_step(input bit r, input bit e, input bit v, input bit c,
                             input bit [31:0] tw, input bit [9:0] off);
      bit        hs, carried, was_run, was_pend;
      bit [32:0] s;
      bit [31:0] nacc;
      if (r) begin
         m_acc = 0; m_act = 0; m_shd = 0; m_run = 0; m_pend = 0; m_wrap = 0; m_phase = 0;
      end else begin
         hs = v && !m_pend;
         was_run = m_run;
         was_pend = m_pend;
         nacc = m_acc;
         carried = 0;
         if (m_run && e) begin
            s = {1'b0, m_acc} + {1'b0, m_act};
            nacc = s[31:0];
            carried = s[32];
         end
         if (!m_run) begin
            if (hs) m_act = tw;
            if (e) m_run = 1;
         end else if (!m_pend) begin
            if (!e) begin
               m_run = 0;
               if (hs) m_act = tw;
            end else if (hs) begin
               m_shd = tw;
               m_pend = 1;
            end
         end else begin
            if (!e) begin
               m_act = m_shd; m_pend = 0; m_run = 0;
            end else if (m_act == 0 || carried) begin
               m_act = m_shd; m_pend = 0;
            end
         end
         m_acc = nacc;
         m_wrap = carried;
         if (was_run) m_phase = nacc[31:22] + off;
         if (c) begin
            m_acc = 0;
            m_wrap = 0;
            m_phase = off;
            if (was_pend) begin
               m_act = m_shd; m_pend = 0; m_run = 1;
            end
         end
      end
   endtask

   initial begin
      bit          r, e, v, c;
      bit [31:0]   tw;
      bit [9:0]    off;
      int          wraps;

      drive(1, 0, 0, 0, 0, 0);

      //            rst en vld clr tw            off  | ph  wr rdy pv
      add(1, 0, 0, 0, 32'h0,         10'd0,   10'd0,   0, 1, 0);
      add(0, 1, 1, 0, 32'h4000_0000, 10'd0,   10'd0,   0, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd256, 0, 1, 1);
      add(0, 1, 1, 0, 32'h8000_0000, 10'd0,   10'd512, 0, 0, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd768, 0, 0, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd0,   1, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd512, 0, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd0,   1, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd512, 0, 1, 1);
      add(0, 1, 1, 1, 32'h4000_0000, 10'd256, 10'd256, 0, 0, 1);
      add(0, 1, 0, 0, 32'h0,         10'd256, 10'd768, 0, 0, 1);
      add(0, 1, 0, 0, 32'h0,         10'd256, 10'd256, 1, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd256, 10'd512, 0, 1, 1);
      add(1, 0, 0, 0, 32'h0,         10'd0,   10'd0,   0, 1, 0);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd0,   0, 1, 1);
      add(0, 1, 1, 0, 32'h4000_0000, 10'd0,   10'd0,   0, 0, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd0,   0, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd256, 0, 1, 1);
      add(0, 1, 1, 0, 32'h1000_0000, 10'd0,   10'd512, 0, 0, 1);
      add(0, 0, 0, 0, 32'h0,         10'd0,   10'd512, 0, 1, 0);
      add(0, 0, 0, 0, 32'h0,         10'd0,   10'd512, 0, 1, 0);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd512, 0, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd576, 0, 1, 1);
      add(0, 1, 1, 0, 32'h4000_0000, 10'd0,   10'd640, 0, 0, 1);
      add(1, 1, 0, 0, 32'h0,         10'd0,   10'd0,   0, 1, 0);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd0,   0, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd0,   0, 1, 1);
      add(0, 1, 0, 0, 32'h0,         10'd0,   10'd0,   0, 1, 1);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].vld, tbl[i].clr, tbl[i].tw, tbl[i].off);
         tick();
         check($sformatf("vec%0d phase_out", i), 32'(phase_out), 32'(tbl[i].ph));
         check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(tbl[i].wr));
         check($sformatf("vec%0d tw_ready", i), 32'(tw_ready), 32'(tbl[i].rdy));
         check($sformatf("vec%0d phase_valid", i), 32'(phase_valid), 32'(tbl[i].pv));
      end

      // Full 1024-step sweep with the smallest step that moves the 10-bit phase.
      drive(1, 0, 0, 0, 0, 0);
      tick();
      drive(0, 1, 1, 0, 32'h0040_0000, 0);
      tick();
      drive(0, 1, 0, 0, 0, 0);
      wraps = 0;
      for (int i = 1; i <= 1024; i++) begin
         tick();
         check("sweep phase_out", 32'(phase_out), 32'(i % 1024));
         check("sweep phase_valid", 32'(phase_valid), 32'd1);
         if (wrap) wraps++;
      end
      check("sweep wrap count", 32'(wraps), 32'd1);
      check("sweep wrap at 0", 32'(wrap), 32'd1);

      // Randomized run against the model, starting from reset.
      model_step(1, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      tick();
      off = 0;
      for (int n = 0; n < 4000; n++) begin
         r = ($urandom_range(0, 299) == 0);
         e = ($urandom_range(0, 9) != 0);
         v = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 59) == 0);
         case ($urandom_range(0, 3))
            0:       tw = 32'h0;
            1:       tw = {$urandom_range(0, 15), 28'h0};
            default: tw = $urandom;
         endcase
         if ($urandom_range(0, 19) == 0) off = 10'($urandom);
         drive(r, e, v, c, tw, off);
         model_step(r, e, v, c, tw, off);
         tick();
         check("rand phase_out", 32'(phase_out), 32'(m_phase));
         check("rand wrap", 32'(wrap), 32'(m_wrap));
         check("rand tw_ready", 32'(tw_ready), 32'(!m_pend));
         check("rand phase_valid", 32'(phase_valid), 32'(m_run));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
